cache_ctrl_nway: RTL
====================

# cache_ctrl_nway

Parametrised write-back, write-allocate cache controller with N-way set associativity. It keeps the tag, valid, dirty and replacement state internally and sequences the external data array and the L2 port. It sits between the CPU load/store port and the L2 interface, and supersedes the single-way tag-compare controller. It adds ready/valid handshakes, victim selection and saturating event counters.

## Interface
- ADDR_W, 32, byte address width
- OFFSET_W, 5, line-offset bits (32-byte lines)
- INDEX_W, 6, set-index bits (64 sets)
- WAYS, 2, associativity; legal values 1, 2, 4
- CNT_W, 32, event counter width
- Derived: TAG_W = ADDR_W-INDEX_W-OFFSET_W (21 at defaults, tag = addr[31:11]); WAY_W = max(1, log2 WAYS)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; clears all state
- cpu_req_valid  in  1  CPU request present
- cpu_req_we  in  1  1 = store, 0 = load
- cpu_req_addr  in  ADDR_W  request byte address
- cpu_req_ready  out  1  controller can accept a request (high only in IDLE)
- cpu_resp_valid  out  1  one-cycle pulse: request complete, array holds/has taken the word
- cpu_resp_hit  out  1  qualifies cpu_resp_valid: 1 if the request hit on first lookup
- arr_index  out  INDEX_W  set index for the data array
- arr_way  out  WAY_W  way for the data array
- data_we  out  1  write CPU store word into array (store hit)
- data_rd_line  out  1  read victim line out for writeback
- data_fill_we  out  1  write L2 line into array
- l2_req_valid  out  1  L2 request present
- l2_req_we  out  1  1 = writeback, 0 = line fill
- l2_req_addr  out  ADDR_W  line-aligned address (offset bits zero)
- l2_req_ready  in  1  L2 accepts request this cycle
- l2_resp_valid  in  1  L2 completion (fill data valid / write done)
- hit_cnt, miss_cnt, wb_cnt  out  CNT_W each  saturating event counters

## Operation
- Per set and way the controller keeps tag[TAG_W], valid and dirty. Per set it keeps a round-robin pointer rr[WAY_W].
- States:
  - IDLE: cpu_req_ready=1. If cpu_req_valid, latch we/addr and go to LOOKUP. Set first=1.
  - LOOKUP: compare the latched tag against all valid ways of the set.
    - Hit: pulse cpu_resp_valid, cpu_resp_hit=first, arr_way=hit way. A store also asserts data_we and sets dirty. Go to IDLE.
    - Miss: choose the victim way as the lowest-index invalid way, otherwise rr[set]. Latch the victim and clear first. If the victim is valid&dirty go to WB_REQ, else FILL_REQ.
  - WB_REQ: l2_req_valid=1, l2_req_we=1, l2_req_addr={victim tag, index, 0}, data_rd_line=1, arr_way=victim. On l2_req_ready go to WB_WAIT.
  - WB_WAIT: wait for l2_resp_valid, then go to FILL_REQ.
  - FILL_REQ: l2_req_valid=1, l2_req_we=0, l2_req_addr={req tag, index, 0}. On l2_req_ready go to FILL_WAIT.
  - FILL_WAIT: on l2_resp_valid, data_fill_we=1 and arr_way=victim. Write the tag, set valid=1, dirty=0, and rr[set]=victim+1 (mod WAYS). Go to LOOKUP, which then hits with cpu_resp_hit=0.
- arr_index always equals the latched index outside IDLE.
- Counters:
  - hit_cnt increments on a LOOKUP hit with first=1.
  - miss_cnt increments on a LOOKUP miss.
  - wb_cnt increments on l2_resp_valid in WB_WAIT.
  - All three hold at all-ones and never wrap.
- WAYS=1: victim is always way 0 and rr is unused.

## Timing
- Reset (reset=0 at a clock edge):
  - State goes to IDLE. All valid, dirty and rr bits clear. Counters clear.
  - All outputs are 0 while reset is low, including cpu_req_ready.
  - cpu_req_ready=1 the first cycle after reset is released.
- Hit latency: request accepted in cycle 0, cpu_resp_valid in cycle 1, cpu_req_ready again in cycle 2. Back-to-back accepted requests are spaced 2 cycles apart.
- Clean miss: l2_req_valid first asserts in cycle 2. Response is 1 cycle after the fill l2_resp_valid cycle.
- Dirty miss: the writeback handshake completes before the fill request is issued.
- l2_req_valid, l2_req_we and l2_req_addr stay stable from assertion until the l2_req_ready cycle. They drop the cycle after the handshake.
- l2_resp_valid outside WB_WAIT/FILL_WAIT is ignored.
- l2_req_ready and l2_resp_valid may both be high in a REQ state; only the ready counts.
- cpu_req_valid outside IDLE is ignored and not latched.
- Reset mid-transaction: the L2 transaction is abandoned and l2_req_valid is low from the next cycle. The L2 side must discard it.
- data_we, data_rd_line, data_fill_we and cpu_resp_valid are single-cycle except data_rd_line, which holds through the WB_REQ stall.

## Test plan
- Cold load 0x0000_1000 (defaults), L2 ready immediately, resp 3 cycles later:
  - fill request addr 0x0000_1000, we=0.
  - then cpu_resp_valid with hit=0.
  - repeat load: resp in cycle 1, hit=1.
  - hit_cnt=1, miss_cnt=1.
- Fill 0x1000 (way0) and 0x1800 (way1), both set 0. Store to 0x1000 (data_we, arr_way=0). Load 0x2000:
  - victim way0 (rr=0).
  - WB addr 0x0000_1000, then fill 0x0000_2000.
  - wb_cnt=1, rr[0]=1 afterwards.
- Hold l2_req_ready low 5 cycles during FILL_REQ: l2_req_valid, we and addr remain constant all 5 cycles. A single request is issued.
- Assert reset low during FILL_WAIT: next cycle l2_req_valid=0 and cpu_req_ready=0. After release, load the previous address and expect a miss (valid cleared). Counters are 0 before that load.
- CNT_W=4, 20 hits: hit_cnt saturates at 15.
- WAYS=1, loads 0x1000 then 0x1800: second load evicts way 0. A clean victim issues no writeback; wb_cnt=0.

Source files
------------

// File: rtl/cache_ctrl_nway_if.sv
// CPU request/response, data-array strobes and L2 request/response of the N-way cache controller.
// The slave view belongs to the controller, the master view to the CPU/L2/array environment.
interface cache_ctrl_nway_if #(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 6,
    parameter int WAY_W   = 1
) ();
    logic               cpu_req_valid;
    logic               cpu_req_we;
    logic [ADDR_W-1:0]  cpu_req_addr;
    logic               cpu_req_ready;
    logic               cpu_resp_valid;
    logic               cpu_resp_hit;

    logic [INDEX_W-1:0] arr_index;
    logic [WAY_W-1:0]   arr_way;
    logic               data_we;
    logic               data_rd_line;
    logic               data_fill_we;

    logic               l2_req_valid;
    logic               l2_req_we;
    logic [ADDR_W-1:0]  l2_req_addr;
    logic               l2_req_ready;
    logic               l2_resp_valid;

    modport slave (
        input  cpu_req_valid, cpu_req_we, cpu_req_addr, l2_req_ready, l2_resp_valid,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_hit, arr_index, arr_way,
               data_we, data_rd_line, data_fill_we, l2_req_valid, l2_req_we, l2_req_addr
    );

    modport master (
        output cpu_req_valid, cpu_req_we, cpu_req_addr, l2_req_ready, l2_resp_valid,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_hit, arr_index, arr_way,
               data_we, data_rd_line, data_fill_we, l2_req_valid, l2_req_we, l2_req_addr
    );
endinterface

// File: rtl/cache_ctrl_nway.sv
// Write-back, write-allocate N-way cache controller: hit answers 1 cycle after accept, misses go via L2.
// Accepts a CPU request only in IDLE; L2 request held stable until l2_req_ready.
module cache_ctrl_nway #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 5,
    parameter int INDEX_W  = 6,
    parameter int WAYS     = 2,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    cache_ctrl_nway_if.slave bus,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] wb_cnt
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int SETS  = 1 << INDEX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT} state_t;

    state_t             state;
    logic [TAG_W-1:0]   tag_mem   [SETS][WAYS];
    logic [WAYS-1:0]    valid_mem [SETS];
    logic [WAYS-1:0]    dirty_mem [SETS];
    logic [WAY_W-1:0]   rr_mem    [SETS];

    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] index_q;
    logic               we_q;
    logic               first_q;
    logic [WAY_W-1:0]   victim_q;

    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic               inv_found;
    logic [WAY_W-1:0]   vict;
    logic               vict_dirty;
    logic [WAY_W-1:0]   rr_next;
    logic [ADDR_W-1:0]  fill_addr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Hit: first matching valid way. Victim: lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        vict      = rr_mem[index_q];
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_mem[index_q][w] && tag_mem[index_q][w] == tag_q) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_mem[index_q][w]) begin
                inv_found = 1'b1;
                vict      = WAY_W'(w);
            end
        end
        if (WAYS == 1)
            vict = '0;
    end

    assign vict_dirty = valid_mem[index_q][vict] & dirty_mem[index_q][vict];
    assign rr_next    = (WAYS == 1) ? '0 : victim_q + WAY_W'(1);
    assign fill_addr  = {tag_q, index_q, {OFFSET_W{1'b0}}};

    assign bus.arr_index      = index_q;
    assign bus.arr_way        = (state == LOOKUP) ? hit_way : victim_q;
    assign bus.cpu_resp_valid = (state == LOOKUP) && hit;
    assign bus.cpu_resp_hit   = (state == LOOKUP) && hit && first_q;
    assign bus.data_we        = (state == LOOKUP) && hit && we_q;
    assign bus.data_fill_we   = (state == FILL_WAIT) && bus.l2_resp_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            bus.cpu_req_ready <= 1'b0;
            bus.l2_req_valid <= 1'b0;
            bus.l2_req_we    <= 1'b0;
            bus.l2_req_addr  <= '0;
            bus.data_rd_line <= 1'b0;
            tag_q            <= '0;
            index_q          <= '0;
            we_q             <= 1'b0;
            first_q          <= 1'b0;
            victim_q         <= '0;
            hit_cnt          <= '0;
            miss_cnt         <= '0;
            wb_cnt           <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                rr_mem[s]    <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    bus.cpu_req_ready <= 1'b1;
                    if (bus.cpu_req_valid && bus.cpu_req_ready) begin
                        bus.cpu_req_ready <= 1'b0;
                        tag_q   <= bus.cpu_req_addr[ADDR_W-1 -: TAG_W];
                        index_q <= bus.cpu_req_addr[OFFSET_W +: INDEX_W];
                        we_q    <= bus.cpu_req_we;
                        first_q <= 1'b1;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (first_q)
                            hit_cnt <= sat_inc(hit_cnt);
                        if (we_q)
                            dirty_mem[index_q][hit_way] <= 1'b1;
                        bus.cpu_req_ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        miss_cnt         <= sat_inc(miss_cnt);
                        victim_q         <= vict;
                        first_q          <= 1'b0;
                        bus.l2_req_valid <= 1'b1;
                        if (vict_dirty) begin
                            bus.l2_req_we    <= 1'b1;
                            bus.l2_req_addr  <= {tag_mem[index_q][vict], index_q, {OFFSET_W{1'b0}}};
                            bus.data_rd_line <= 1'b1;
                            state            <= WB_REQ;
                        end else begin
                            bus.l2_req_we   <= 1'b0;
                            bus.l2_req_addr <= fill_addr;
                            state           <= FILL_REQ;
                        end
                    end
                end
                WB_REQ: begin
                    if (bus.l2_req_ready) begin
                        bus.l2_req_valid <= 1'b0;
                        bus.l2_req_we    <= 1'b0;
                        bus.l2_req_addr  <= '0;
                        bus.data_rd_line <= 1'b0;
                        state            <= WB_WAIT;
                    end
                end
                WB_WAIT: begin
                    if (bus.l2_resp_valid) begin
                        wb_cnt           <= sat_inc(wb_cnt);
                        bus.l2_req_valid <= 1'b1;
                        bus.l2_req_we    <= 1'b0;
                        bus.l2_req_addr  <= fill_addr;
                        state            <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (bus.l2_req_ready) begin
                        bus.l2_req_valid <= 1'b0;
                        bus.l2_req_addr  <= '0;
                        state            <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    // The following LOOKUP is guaranteed to hit the freshly filled way.
                    if (bus.l2_resp_valid) begin
                        tag_mem[index_q][victim_q]   <= tag_q;
                        valid_mem[index_q][victim_q] <= 1'b1;
                        dirty_mem[index_q][victim_q] <= 1'b0;
                        rr_mem[index_q]              <= rr_next;
                        state                        <= LOOKUP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
